next_pc_stage: RTL and testbench
================================

Name: next_pc_stage

Overview:
- Pipeline stage directly upstream of the fetch stage.
- Owns the architectural fetch PC register and issues one fetch-group head PC per cycle to fetch.
- Selects the next PC from, in priority order:
  - backend recovery;
  - stall hold;
  - fetch-stage branch prediction (AX BTB decider, BTB plus PHT, RAS);
  - sequential group increment.
- Consumes the fetch stage's per-lane valid/PC, BTB, RAS, AX BTB and decider results. Produces the PC and valid that the fetch stage latches.

Parameters:
- FETCH_WIDTH, 2, lanes per fetch group; must be a power of two.
- PC_WIDTH, 32, PC_Path width in bits.
- INSN_BYTES, 4, bytes per instruction.
- RESET_PC, 32'h0000_1000, first PC fetched after reset.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- rstStart  in  1  high while the reset sequence is still running; fetch is held off while it is high.
- stall  in  1  fetch stage cannot accept a new PC this cycle.
- recover  in  1  backend misprediction/exception redirect.
- recoverPC  in  PC_WIDTH  redirect target.
- fetchStageIsValid  in  FETCH_WIDTH  per-lane valid of the group currently in fetch.
- fetchStagePC  in  FETCH_WIDTH*PC_WIDTH  per-lane PC in fetch.
- btbHit  in  FETCH_WIDTH  BTB hit per lane.
- btbOut  in  FETCH_WIDTH*PC_WIDTH  BTB target per lane.
- brPredTaken  in  FETCH_WIDTH  PHT taken per lane.
- readIsRASPopBr  in  FETCH_WIDTH  BTB entry is a return.
- rasOut  in  FETCH_WIDTH*PC_WIDTH  RAS target per lane.
- axbtbHit  in  FETCH_WIDTH  AX BTB hit per lane.
- axbtbOut  in  FETCH_WIDTH*PC_WIDTH  AX BTB target per lane.
- brDecidTaken  in  FETCH_WIDTH  decider taken per lane.
- npPC  out  PC_WIDTH  PC sent to fetch (registered).
- npValid  out  1  npPC is valid this cycle.
- npRedirected  out  1  one-cycle pulse: npPC came from a predicted-taken branch or from recovery.

Behaviour:
- Reset (rst=0, asynchronous):
  - pc register = RESET_PC.
  - state = RESET_WAIT.
  - npValid = 0.
  - npRedirected = 0.
- States:
  - RESET_WAIT -> RUN on the first clock edge with rstStart=0. npValid=0 while in RESET_WAIT.
  - RUN -> STALLED when stall=1.
  - STALLED -> RUN when stall=0.
  - npValid=1 in RUN and STALLED.
- Per-lane take condition (lane i):
  - valid = fetchStageIsValid[i].
  - Lane i is taken if it is valid and either:
    - axbtbHit[i] and brDecidTaken[i]; target = axbtbOut[i], highest priority; or
    - btbHit[i] and brPredTaken[i]; target = btbOut[i].
  - Return override: if the BTB source applies and readIsRASPopBr[i]=1, target = rasOut[i] instead of btbOut[i]. Subject to the optional feature.
  - The lowest-indexed taken lane wins. Higher lanes are ignored.
- Sequential PC:
  - seq = (pc & ~(FETCH_WIDTH*INSN_BYTES-1)) + FETCH_WIDTH*INSN_BYTES.
  - Arithmetic is modulo 2^PC_WIDTH. 0xFFFF_FFF8 with FETCH_WIDTH=2 wraps to 0x0.
- Next-pc priority, evaluated each cycle and registered on the clock edge:
  1. recover=1 in RUN or STALLED: pc <= recoverPC, npRedirected <= 1, state unchanged. This overrides stall, so the new PC is held during the stall.
  2. state RESET_WAIT: pc holds RESET_PC and recover is ignored.
  3. stall=1: pc holds, npRedirected <= 0.
  4. Some lane taken: pc <= target, npRedirected <= 1.
  5. Otherwise: pc <= seq, npRedirected <= 0.
- Timing and output relations:
  - Latency is one cycle from fetch-stage prediction inputs to npPC.
  - npPC = pc register; no combinational path from inputs to npPC.
  - Entering RUN from RESET_WAIT: the first RUN cycle presents npPC = RESET_PC with npValid=1.
- Boundary cases:
  - Reset asserted mid-operation discards any pending redirect.
  - If no lane is valid, sequential applies.

Optional Feature:
- Macro RSD_NEXTPC_RAS_PREDICT_EN.
- Defined: the RAS return override applies as described above.
- Undefined: readIsRASPopBr and rasOut are ignored, and return branches use btbOut.

Decomposition:
- FetchUnitTypes package:
  - NextPC_StateType enum {NP_RESET_WAIT, NP_RUN, NP_STALLED}.
  - FETCH_GROUP_BYTES constant.
  - existing PC_Path type.
- One sub-module, next_pc_lane_select: combinational priority encoder over lanes producing taken and target. All sequential logic stays in the parent.

Test Plan (FETCH_WIDTH=2, RESET_PC=0x1000):
- Reset release: rst low then high, rstStart high 3 cycles then low -> npValid=0 for those cycles; then npPC 0x1000, 0x1008, 0x1010 with npValid=1.
- Stall: stall=1 for 2 cycles while npPC=0x1008 -> npPC stays 0x1008 and npRedirected=0; after release npPC=0x1010.
- BTB taken: lane1 valid, btbHit=1, brPredTaken=1, btbOut=0x2000; lane0 not taken -> next npPC=0x2000, npRedirected=1.
- Priority: lane0 axbtbHit=1, brDecidTaken=1, axbtbOut=0x3000; lane1 BTB-taken to 0x2000 -> npPC=0x3000.
- Recover under stall: stall=1 and recover=1 with recoverPC=0x4004 -> npPC=0x4004 while still stalled; after release npPC=0x4008.
- RAS pop: lane0 btbHit=1, brPredTaken=1, readIsRASPopBr=1, rasOut=0x5000, btbOut=0x6000 -> npPC=0x5000 with the macro defined, 0x6000 without it.
- Wrap: pc=0xFFFF_FFF8, no prediction -> npPC=0x0000_0000.

Source files
------------

// File: rtl/next_pc_stage_pkg.sv
// Fetch unit shared types: PC path, next-PC FSM states, group geometry.
// Consumed by next_pc_stage and its lane selector.
package FetchUnitTypes;

  localparam int FETCH_WIDTH = 2;
  localparam int PC_WIDTH = 32;
  localparam int INSN_BYTES = 4;
  localparam int FETCH_GROUP_BYTES =
    FETCH_WIDTH * INSN_BYTES;

  typedef logic [PC_WIDTH-1:0] PC_Path;

  typedef enum logic [1:0] {
    NP_RESET_WAIT,
    NP_RUN,
    NP_STALLED
  } NextPC_StateType;

  function automatic PC_Path seqPC(PC_Path pc);
    PC_Path mask;
    mask = PC_Path'(FETCH_GROUP_BYTES - 1);
    return (pc & ~mask) +
      PC_Path'(FETCH_GROUP_BYTES);
  endfunction

endpackage

// File: rtl/next_pc_stage_if.sv
// Bundle between next-PC stage and fetch stage: redirect,
// stall, per-lane prediction results and the issued PC.
interface next_pc_if;
  import FetchUnitTypes::*;

  logic stall;
  logic recover;
  PC_Path recoverPC;
  logic [FETCH_WIDTH-1:0] fetchStageIsValid;
  PC_Path [FETCH_WIDTH-1:0] fetchStagePC;
  logic [FETCH_WIDTH-1:0] btbHit;
  PC_Path [FETCH_WIDTH-1:0] btbOut;
  logic [FETCH_WIDTH-1:0] brPredTaken;
  logic [FETCH_WIDTH-1:0] readIsRASPopBr;
  PC_Path [FETCH_WIDTH-1:0] rasOut;
  logic [FETCH_WIDTH-1:0] axbtbHit;
  PC_Path [FETCH_WIDTH-1:0] axbtbOut;
  logic [FETCH_WIDTH-1:0] brDecidTaken;
  PC_Path npPC;
  logic npValid;
  logic npRedirected;

  modport master (
    output stall, recover, recoverPC,
    output fetchStageIsValid, fetchStagePC,
    output btbHit, btbOut, brPredTaken,
    output readIsRASPopBr, rasOut,
    output axbtbHit, axbtbOut, brDecidTaken,
    input npPC, npValid, npRedirected
  );

  modport slave (
    input stall, recover, recoverPC,
    input fetchStageIsValid, fetchStagePC,
    input btbHit, btbOut, brPredTaken,
    input readIsRASPopBr, rasOut,
    input axbtbHit, axbtbOut, brDecidTaken,
    output npPC, npValid, npRedirected
  );

endinterface

// File: rtl/next_pc_stage_lane_select.sv
// Lowest-lane-first taken-branch picker; RAS return override
// is compiled in only with RSD_NEXTPC_RAS_PREDICT_EN.
module next_pc_lane_select
  import FetchUnitTypes::*;
(
  input  logic [FETCH_WIDTH-1:0] valid,
  input  logic [FETCH_WIDTH-1:0] axbtbHit,
  input  PC_Path [FETCH_WIDTH-1:0] axbtbOut,
  input  logic [FETCH_WIDTH-1:0] brDecidTaken,
  input  logic [FETCH_WIDTH-1:0] btbHit,
  input  PC_Path [FETCH_WIDTH-1:0] btbOut,
  input  logic [FETCH_WIDTH-1:0] brPredTaken,
`ifdef RSD_NEXTPC_RAS_PREDICT_EN
  input  logic [FETCH_WIDTH-1:0] readIsRASPopBr,
  input  PC_Path [FETCH_WIDTH-1:0] rasOut,
`endif
  output logic taken,
  output PC_Path target
);

  always_comb begin
    taken = 1'b0;
    target = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (!taken && valid[i]) begin
        if (axbtbHit[i] && brDecidTaken[i]) begin
          taken = 1'b1;
          target = axbtbOut[i];
        end else if (btbHit[i] && brPredTaken[i]) begin
          taken = 1'b1;
`ifdef RSD_NEXTPC_RAS_PREDICT_EN
          target = readIsRASPopBr[i] ?
            rasOut[i] : btbOut[i];
`else
          target = btbOut[i];
`endif
        end
      end
    end
  end

endmodule

// File: rtl/next_pc_stage.sv
// Fetch PC owner: recovery > stall > prediction > sequential.
// Build option: RSD_NEXTPC_RAS_PREDICT_EN enables RAS returns.
module next_pc_stage
  import FetchUnitTypes::*;
#(
  parameter PC_Path RESET_PC = 32'h0000_1000
) (
  input logic clk,
  input logic rst,
  input logic rstStart,
  next_pc_if.slave port
);

  NextPC_StateType state, nextState;
  PC_Path pc, nextPC;
  logic redir, nextRedir;
  logic taken;
  PC_Path target;

  next_pc_lane_select laneSel (
    .valid        (port.fetchStageIsValid),
    .axbtbHit     (port.axbtbHit),
    .axbtbOut     (port.axbtbOut),
    .brDecidTaken (port.brDecidTaken),
    .btbHit       (port.btbHit),
    .btbOut       (port.btbOut),
    .brPredTaken  (port.brPredTaken),
`ifdef RSD_NEXTPC_RAS_PREDICT_EN
    .readIsRASPopBr (port.readIsRASPopBr),
    .rasOut         (port.rasOut),
`endif
    .taken        (taken),
    .target       (target)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= NP_RESET_WAIT;
      pc <= RESET_PC;
      redir <= 1'b0;
    end else begin
      state <= nextState;
      pc <= nextPC;
      redir <= nextRedir;
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      NP_RESET_WAIT:
        if (!rstStart) nextState = NP_RUN;
      NP_RUN:
        if (!port.recover && port.stall)
          nextState = NP_STALLED;
      NP_STALLED:
        if (!port.recover && !port.stall)
          nextState = NP_RUN;
      default: nextState = NP_RESET_WAIT;
    endcase
  end

  // Recovery wins even over stall so the new PC is held.
  always_comb begin
    nextPC = pc;
    nextRedir = 1'b0;
    if (state == NP_RESET_WAIT) begin
      nextPC = pc;
    end else if (port.recover) begin
      nextPC = port.recoverPC;
      nextRedir = 1'b1;
    end else if (port.stall) begin
      nextPC = pc;
    end else if (taken) begin
      nextPC = target;
      nextRedir = 1'b1;
    end else begin
      nextPC = seqPC(pc);
    end
  end

  always_comb begin
    port.npPC = pc;
    port.npValid = (state != NP_RESET_WAIT);
    port.npRedirected = redir;
  end

endmodule

// File: tb/tb_next_pc_stage.sv
// Directed table-driven bench for next_pc_stage.
// Honors RSD_NEXTPC_RAS_PREDICT_EN for the RAS vector.
module tb_next_pc_stage;
  import FetchUnitTypes::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rstStart = 1'b1;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  next_pc_if bus ();

  next_pc_stage #(.RESET_PC(32'h0000_1000)) dut (
    .clk      (clk),
    .rst      (rst),
    .rstStart (rstStart),
    .port     (bus.slave)
  );

  localparam PC_Path RAS_T =
`ifdef RSD_NEXTPC_RAS_PREDICT_EN
    32'h0000_5000;
`else
    32'h0000_6000;
`endif

  typedef struct packed {
    logic stall;
    logic recover;
    PC_Path recoverPC;
    logic [1:0] valid;
    logic [1:0] btbHit;
    PC_Path [1:0] btbOut;
    logic [1:0] pred;
    logic [1:0] ras;
    PC_Path [1:0] rasOut;
    logic [1:0] axHit;
    PC_Path [1:0] axOut;
    logic [1:0] decid;
    PC_Path expPC;
    logic expValid;
    logic expRedir;
  } vec_t;

  localparam int NV = 18;
  vec_t tv [NV];

  task automatic chk(string name, PC_Path act, PC_Path exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    bus.stall = v.stall;
    bus.recover = v.recover;
    bus.recoverPC = v.recoverPC;
    bus.fetchStageIsValid = v.valid;
    bus.fetchStagePC = '0;
    bus.btbHit = v.btbHit;
    bus.btbOut = v.btbOut;
    bus.brPredTaken = v.pred;
    bus.readIsRASPopBr = v.ras;
    bus.rasOut = v.rasOut;
    bus.axbtbHit = v.axHit;
    bus.axbtbOut = v.axOut;
    bus.brDecidTaken = v.decid;
  endtask

  task automatic chkOut(string n, PC_Path p, logic v, logic r);
    chk({n, ".npPC"}, bus.npPC, p);
    chk({n, ".npValid"}, PC_Path'(bus.npValid), PC_Path'(v));
    chk({n, ".npRedir"}, PC_Path'(bus.npRedirected),
        PC_Path'(r));
  endtask

  initial begin
    for (int i = 0; i < NV; i++) tv[i] = '0;
    // reset release and sequential run
    tv[0].expPC = 32'h1000; tv[0].expValid = 1;
    tv[1].expPC = 32'h1008; tv[1].expValid = 1;
    // stall hold for two cycles
    tv[2].stall = 1; tv[2].expPC = 32'h1008;
    tv[2].expValid = 1;
    tv[3].stall = 1; tv[3].expPC = 32'h1008;
    tv[3].expValid = 1;
    tv[4].expPC = 32'h1010; tv[4].expValid = 1;
    // lane1 BTB taken
    tv[5].valid = 2'b11; tv[5].btbHit = 2'b10;
    tv[5].pred = 2'b10; tv[5].btbOut[1] = 32'h2000;
    tv[5].expPC = 32'h2000; tv[5].expValid = 1;
    tv[5].expRedir = 1;
    tv[6].expPC = 32'h2008; tv[6].expValid = 1;
    // lane0 AX BTB beats lane1 BTB
    tv[7].valid = 2'b11; tv[7].axHit = 2'b01;
    tv[7].decid = 2'b01; tv[7].axOut[0] = 32'h3000;
    tv[7].btbHit = 2'b10; tv[7].pred = 2'b10;
    tv[7].btbOut[1] = 32'h2000;
    tv[7].expPC = 32'h3000; tv[7].expValid = 1;
    tv[7].expRedir = 1;
    // recover during stall
    tv[8].stall = 1; tv[8].recover = 1;
    tv[8].recoverPC = 32'h4004;
    tv[8].expPC = 32'h4004; tv[8].expValid = 1;
    tv[8].expRedir = 1;
    tv[9].stall = 1; tv[9].expPC = 32'h4004;
    tv[9].expValid = 1;
    tv[10].expPC = 32'h4008; tv[10].expValid = 1;
    // return via RAS or BTB
    tv[11].valid = 2'b01; tv[11].btbHit = 2'b01;
    tv[11].pred = 2'b01; tv[11].ras = 2'b01;
    tv[11].rasOut[0] = 32'h5000;
    tv[11].btbOut[0] = 32'h6000;
    tv[11].expPC = RAS_T; tv[11].expValid = 1;
    tv[11].expRedir = 1;
    // hits on invalid lanes are ignored
    tv[12].btbHit = 2'b11; tv[12].pred = 2'b11;
    tv[12].btbOut[0] = 32'h7000;
    tv[12].btbOut[1] = 32'h7000;
    tv[12].expPC = RAS_T + 32'h8; tv[12].expValid = 1;
    // lane0 not taken, lane1 AX not decided, lane1 BTB taken
    tv[13].valid = 2'b11; tv[13].btbHit = 2'b11;
    tv[13].pred = 2'b10; tv[13].btbOut[0] = 32'h7700;
    tv[13].btbOut[1] = 32'h7100;
    tv[13].axHit = 2'b10; tv[13].axOut[1] = 32'h7200;
    tv[13].expPC = 32'h7100; tv[13].expValid = 1;
    tv[13].expRedir = 1;
    // recover in RUN, then wrap
    tv[14].recover = 1; tv[14].recoverPC = 32'hFFFF_FFF8;
    tv[14].valid = 2'b01; tv[14].btbHit = 2'b01;
    tv[14].pred = 2'b01; tv[14].btbOut[0] = 32'h9999_0000;
    tv[14].expPC = 32'hFFFF_FFF8; tv[14].expValid = 1;
    tv[14].expRedir = 1;
    tv[15].expPC = 32'h0; tv[15].expValid = 1;
    tv[16].expPC = 32'h8; tv[16].expValid = 1;
    // both lanes taken: lowest wins
    tv[17].valid = 2'b11; tv[17].btbHit = 2'b01;
    tv[17].pred = 2'b01; tv[17].btbOut[0] = 32'h8000;
    tv[17].axHit = 2'b10; tv[17].decid = 2'b10;
    tv[17].axOut[1] = 32'h9000;
    tv[17].expPC = 32'h8000; tv[17].expValid = 1;
    tv[17].expRedir = 1;

    drive('0);
    repeat (2) @(negedge clk);
    chkOut("reset", 32'h1000, 1'b0, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chkOut($sformatf("rstStart%0d", i),
             32'h1000, 1'b0, 1'b0);
    end
    rstStart = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(tv[i]);
      @(negedge clk);
      chkOut($sformatf("vec%0d", i),
             tv[i].expPC, tv[i].expValid, tv[i].expRedir);
    end

    // async reset mid-cycle drops a pending redirect
    drive('0);
    bus.recover = 1'b1;
    bus.recoverPC = 32'h0000_ABC0;
    #2 rst = 1'b0;
    #1 chkOut("asyncRst", 32'h1000, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    rstStart = 1'b1;
    @(negedge clk);
    chkOut("waitIgnRecover", 32'h1000, 1'b0, 1'b0);
    rstStart = 1'b0;
    bus.recover = 1'b0;
    @(negedge clk);
    chkOut("rerun0", 32'h1000, 1'b1, 1'b0);
    @(negedge clk);
    chkOut("rerun1", 32'h1008, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
